// File: rtl/fp_op_arbiter.sv
// Round-robin arbiter sharing one variable-latency FP unit among NUM_REQ requesters.
// One operation in flight at a time; result routed back to its owner, watchdog aborts hung ops.
module fp_op_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DBL_WIDTH      = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DBL_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DBL_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           resp_valid,
  output logic [DBL_WIDTH-1:0]         resp_result,
  output logic                         unit_valid,
  output logic [DBL_WIDTH-1:0]         unit_a,
  output logic [DBL_WIDTH-1:0]         unit_b,
  input  logic                         unit_finish,
  input  logic [DBL_WIDTH-1:0]         unit_result,
  output logic                         busy,
  output logic                         timeout_err,
  output logic [15:0]                  op_count
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0]      WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]     IDX_INIT = IDX_W'(NUM_REQ - 1);
  localparam logic [DBL_WIDTH-1:0] QNAN     = DBL_WIDTH'(64'h7FF8_0000_0000_0000);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t               r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_last;
  logic [WD_W-1:0]      r_wd;
  logic [NUM_REQ-1:0]   r_req_ready, r_resp_valid;
  logic [DBL_WIDTH-1:0] r_resp_result, r_unit_a, r_unit_b;
  logic                 r_unit_valid, r_busy, r_timeout_err;
  logic [15:0]          r_op_count;

  logic                 w_found, w_grant, w_done, w_abort;
  logic [IDX_W-1:0]     w_gnt;
  logic [DBL_WIDTH-1:0] w_a_arr [NUM_REQ];
  logic [DBL_WIDTH-1:0] w_b_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_a_arr[gi] = req_a[gi*DBL_WIDTH +: DBL_WIDTH];
    assign w_b_arr[gi] = req_b[gi*DBL_WIDTH +: DBL_WIDTH];
  end

  // Scan downwards so the candidate closest after 'last' is written last and wins.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                             input logic [IDX_W-1:0]   last);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] idx;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IDX_W'((int'(last) + k) % NUM_REQ);
      if (v[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign {w_found, w_gnt} = rr_pick(req_valid, r_last);

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A finish on the final watchdog cycle still counts as a normal completion.
        if (unit_finish) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (TIMEOUT_CYCLES != 0 && r_wd == WD_LAST) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // r_last doubles as the owner of the in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_last        <= IDX_INIT;
      r_wd          <= '0;
      r_req_ready   <= '0;
      r_resp_valid  <= '0;
      r_resp_result <= '0;
      r_unit_valid  <= 1'b0;
      r_unit_a      <= '0;
      r_unit_b      <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_op_count    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_ready  <= '0;
      r_unit_valid <= 1'b0;
      r_resp_valid <= '0;
      if (w_grant) begin
        r_unit_a           <= w_a_arr[w_gnt];
        r_unit_b           <= w_b_arr[w_gnt];
        r_unit_valid       <= 1'b1;
        r_req_ready[w_gnt] <= 1'b1;
        r_last             <= w_gnt;
        r_busy             <= 1'b1;
        r_wd               <= '0;
      end
      if (w_done || w_abort) begin
        r_resp_valid[r_last] <= 1'b1;
        r_resp_result        <= w_done ? unit_result : QNAN;
        r_op_count           <= r_op_count + 16'd1;
        r_busy               <= 1'b0;
      end
      if (w_abort) r_timeout_err <= 1'b1;
      if (r_state == S_WAIT && !unit_finish) r_wd <= r_wd + WD_W'(1);
    end
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_result = r_resp_result;
  assign unit_valid  = r_unit_valid;
  assign unit_a      = r_unit_a;
  assign unit_b      = r_unit_b;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;
  assign op_count    = r_op_count;

endmodule

// File: tb/tb_fp_op_arbiter.sv
// Scoreboard bench for fp_op_arbiter: transaction-level reference model, randomized requesters,
// behavioural multiplier unit with configurable latency, directed scenarios for the corner cases.
module tb_fp_op_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int W  = 64;
  localparam int TO = 8;
  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*W-1:0]   req_a = '0, req_b = '0;
  logic [N-1:0]     req_ready, resp_valid;
  logic [W-1:0]     resp_result, unit_a, unit_b;
  logic             unit_valid, busy, timeout_err;
  logic             unit_finish = 1'b0;
  logic [W-1:0]     unit_result = '0;
  logic [15:0]      op_count;

  fp_op_arbiter #(.NUM_REQ(N), .DBL_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_result(resp_result),
    .unit_valid(unit_valid), .unit_a(unit_a), .unit_b(unit_b),
    .unit_finish(unit_finish), .unit_result(unit_result),
    .busy(busy), .timeout_err(timeout_err), .op_count(op_count)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic bitof(input logic [N-1:0] v, input int j);
    return v[j[IW-1:0]];
  endfunction

  typedef struct { int g; logic [63:0] a; logic [63:0] b; } gnt_t;
  typedef struct { int g; logic [63:0] res; logic err; logic [15:0] cnt; } rsp_t;
  gnt_t gq[$];
  rsp_t rq[$];
  int   glog[$];

  // Reference model: decides grants and results from the bench-driven inputs only.
  int          cyc = 0;
  bit          m_idle = 1'b1;
  int          m_last = N - 1, m_owner = 0, m_cnt = 0;
  logic        m_err = 1'b0;
  logic [15:0] m_ops = '0;
  logic [63:0] m_prod = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_idle = 1'b1; m_last = N - 1; m_cnt = 0; m_err = 1'b0; m_ops = '0;
      gq.delete(); rq.delete();
    end else if (m_idle) begin
      if (req_valid != '0) begin
        int   g;
        gnt_t e;
        g = -1;
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (m_last + k) % N;
          if (g < 0 && bitof(req_valid, j)) g = j;
        end
        e.g = g;
        e.a = W'(req_a >> (g * W));
        e.b = W'(req_b >> (g * W));
        gq.push_back(e);
        m_prod  = $realtobits($bitstoreal(e.a) * $bitstoreal(e.b));
        m_owner = g; m_last = g; m_idle = 1'b0; m_cnt = 0;
      end
    end else if (unit_finish) begin
      rsp_t r;
      m_ops++;
      r.g = m_owner; r.res = m_prod; r.err = m_err; r.cnt = m_ops;
      rq.push_back(r);
      m_idle = 1'b1;
    end else begin
      m_cnt++;
      if (m_cnt == TO) begin
        rsp_t r;
        m_err = 1'b1;
        m_ops++;
        r.g = m_owner; r.res = QNAN; r.err = 1'b1; r.cnt = m_ops;
        rq.push_back(r);
        m_idle = 1'b1;
      end
    end
  end

  // Monitor: every expectation is due in the cycle it was pushed.
  int n_resp = 0, g_cyc = -1, r_cyc = -1;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      g_cyc = -1;
    end else begin
      if (req_ready != '0 || gq.size() != 0) begin
        int obs;
        obs = -1;
        for (int j = 0; j < N; j++) if (bitof(req_ready, j)) obs = j;
        if (obs >= 0) glog.push_back(obs);
        if (gq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL grant_unexpected: req_ready=%b, expected no grant", req_ready);
        end else begin
          gnt_t e;
          e = gq.pop_front();
          chk("grant_onehot", 64'(req_ready), 64'(1) << e.g);
          chk("unit_valid", 64'(unit_valid), 64'(1));
          chk("unit_a", unit_a, e.a);
          chk("unit_b", unit_b, e.b);
          chk("busy_on_grant", 64'(busy), 64'(1));
          if (g_cyc >= 0) chk("grant_spacing_ge2", 64'((cyc - g_cyc) >= 2), 64'(1));
          g_cyc = cyc;
        end
      end else if (unit_valid) begin
        n_cmp++; n_err++;
        $display("FAIL unit_valid_alone: unit_valid=1, expected 0 without grant");
      end
      if (resp_valid != '0 || rq.size() != 0) begin
        n_resp++;
        r_cyc = cyc;
        if (rq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL resp_unexpected: resp_valid=%b, expected none", resp_valid);
        end else begin
          rsp_t r;
          r = rq.pop_front();
          chk("resp_onehot", 64'(resp_valid), 64'(1) << r.g);
          chk("resp_result", resp_result, r.res);
          chk("timeout_err", 64'(timeout_err), 64'(r.err));
          chk("op_count", 64'(op_count), 64'(r.cnt));
          chk("busy_on_resp", 64'(busy), 64'(0));
        end
      end
    end
  end

  // Requesters.
  bit          rand_en = 1'b0;
  bit          pend [N], want [N], rv [N];
  logic [63:0] ra [N], rb [N], wa [N], wb [N];

  function automatic logic [63:0] rnd_dbl();
    return $realtobits(real'(int'($urandom_range(0, 2000)) - 1000) / 8.0);
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; want[i] = 1'b0; rv[i] = 1'b0;
      ra[i] = '0; rb[i] = '0; wa[i] = '0; wb[i] = '0;
    end
    forever begin
      logic [N-1:0]   v;
      logic [N*W-1:0] pa, pb;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!rst_n) begin
          rv[i] = 1'b0; pend[i] = 1'b0;
        end else begin
          if (bitof(req_ready, i)) rv[i] = 1'b0;
          if (bitof(resp_valid, i)) pend[i] = 1'b0;
          if (rand_en && rv[i] && $urandom_range(0, 15) == 0) begin
            rv[i] = 1'b0; pend[i] = 1'b0;
          end
          if (!pend[i] && (want[i] || (rand_en && $urandom_range(0, 3) == 0))) begin
            pend[i] = 1'b1; rv[i] = 1'b1;
            if (want[i]) begin
              ra[i] = wa[i]; rb[i] = wb[i]; want[i] = 1'b0;
            end else begin
              ra[i] = rnd_dbl(); rb[i] = rnd_dbl();
            end
          end
        end
      end
      v = '0; pa = '0; pb = '0;
      for (int i = 0; i < N; i++) begin
        v[i[IW-1:0]] = rv[i];
        pa = pa | ((N*W)'(ra[i]) << (i * W));
        pb = pb | ((N*W)'(rb[i]) << (i * W));
      end
      req_valid = v; req_a = pa; req_b = pb;
    end
  end

  // Behavioural multiplier: fix_d <0 random latency, 0 never finishes, >0 fixed latency.
  int fix_d = 2, rem = 0;
  bit stray = 1'b0;
  initial forever begin
    @(negedge clk);
    unit_finish = 1'b0;
    if (!rst_n) begin
      rem = 0;
    end else begin
      if (stray) begin
        unit_finish = 1'b1; unit_result = '0; stray = 1'b0;
      end
      if (resp_valid != '0) rem = 0;
      if (unit_valid) rem = (fix_d < 0) ? int'($urandom_range(1, 11)) : fix_d;
      if (rem == 1) begin
        unit_finish = 1'b1;
        unit_result = $realtobits($bitstoreal(unit_a) * $bitstoreal(unit_b));
        rem = 0;
      end else if (rem > 1) begin
        rem--;
      end
    end
  end

  task automatic req(input int i, input logic [63:0] a, input logic [63:0] b);
    wa[i] = a; wb[i] = b; want[i] = 1'b1;
  endtask

  task automatic wait_resp(input int target, input int budget, input string tag);
    int c;
    c = 0;
    while (n_resp < target && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (n_resp < target) begin
      n_cmp++; n_err++;
      $display("FAIL %s: responses seen %0d after %0d cycles, expected %0d", tag, n_resp, c, target);
    end
    @(negedge clk);
  endtask

  task automatic wait_grant(input int target, input int budget, input string tag);
    int c;
    c = 0;
    while (glog.size() < target && c < budget) begin
      @(posedge clk);
      c++;
    end
    if (glog.size() < target) begin
      n_cmp++; n_err++;
      $display("FAIL %s: grants seen %0d after %0d cycles, expected %0d", tag, glog.size(), c, target);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    glog.delete();
  endtask

  function automatic logic [15:0] pack_log();
    logic [15:0] v;
    v = '0;
    foreach (glog[k]) v = (v << 4) | 16'(glog[k]);
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
    chk({tag, "_resp_result"}, resp_result, 64'(0));
    chk({tag, "_unit_valid"}, 64'(unit_valid), 64'(0));
    chk({tag, "_unit_a"}, unit_a, 64'(0));
    chk({tag, "_unit_b"}, unit_b, 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_timeout_err"}, 64'(timeout_err), 64'(0));
    chk({tag, "_op_count"}, 64'(op_count), 64'(0));
  endtask

  initial begin
    int r0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Single request: 3.0 * 2.0, unit answers 5 cycles after start.
    fix_d = 5;
    @(posedge clk);
    req(0, 64'h4008_0000_0000_0000, 64'h4000_0000_0000_0000);
    wait_resp(1, 50, "single_wait");
    chk("single_result", resp_result, 64'h4018_0000_0000_0000);
    chk("single_op_count", 64'(op_count), 64'(1));
    chk("single_unit_a", unit_a, 64'h4008_0000_0000_0000);
    chk("single_latency", 64'(r_cyc - g_cyc), 64'(5));
    chk("single_order", 64'(pack_log()), 64'h0);

    // All four from reset: plain round-robin order.
    do_reset();
    fix_d = 2;
    @(posedge clk);
    for (int i = 0; i < N; i++) req(i, rnd_dbl(), rnd_dbl());
    wait_resp(n_resp + 4, 100, "all4_wait");
    chk("all4_order", 64'(pack_log()), 64'h0123);
    chk("all4_op_count", 64'(op_count), 64'(4));

    // Fairness: after 2 is served, 3 comes before 0.
    glog.delete();
    fix_d = 3;
    r0 = n_resp;
    @(posedge clk);
    req(2, rnd_dbl(), rnd_dbl());
    wait_grant(1, 50, "fair_grant_wait");
    @(posedge clk);
    req(0, rnd_dbl(), rnd_dbl());
    req(3, rnd_dbl(), rnd_dbl());
    wait_resp(r0 + 3, 100, "fair_wait");
    chk("fair_order", 64'(pack_log()), 64'h0230);

    // Watchdog abort, then normal service with the sticky error still set.
    fix_d = 0;
    @(posedge clk);
    req(1, rnd_dbl(), rnd_dbl());
    wait_resp(n_resp + 1, 50, "wd_wait");
    chk("wd_result", resp_result, QNAN);
    chk("wd_err", 64'(timeout_err), 64'(1));
    chk("wd_latency", 64'(r_cyc - g_cyc), 64'(TO));
    fix_d = 3;
    @(posedge clk);
    req(2, 64'h3FF8_0000_0000_0000, 64'h4010_0000_0000_0000);
    wait_resp(n_resp + 1, 50, "wd_after_wait");
    chk("wd_after_result", resp_result, 64'h4018_0000_0000_0000);
    chk("wd_after_err_sticky", 64'(timeout_err), 64'(1));

    // Finish on the last watchdog cycle wins.
    do_reset();
    chk("rst_clears_err", 64'(timeout_err), 64'(0));
    fix_d = TO;
    @(posedge clk);
    req(0, 64'h3FF8_0000_0000_0000, 64'h4010_0000_0000_0000);
    wait_resp(n_resp + 1, 50, "edge_wait");
    chk("edge_result", resp_result, 64'h4018_0000_0000_0000);
    chk("edge_err", 64'(timeout_err), 64'(0));
    chk("edge_latency", 64'(r_cyc - g_cyc), 64'(TO));

    // Reset while waiting, then a late finish in IDLE.
    do_reset();
    fix_d = 0;
    @(posedge clk);
    req(1, rnd_dbl(), rnd_dbl());
    wait_grant(1, 50, "midrst_grant_wait");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midrst_busy_before", 64'(busy), 64'(1));
    r0 = n_resp;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    glog.delete();
    stray = 1'b1;
    repeat (4) @(negedge clk);
    chk("stray_no_resp", 64'(n_resp), 64'(r0));
    chk("stray_op_count", 64'(op_count), 64'(0));
    fix_d = 2;
    @(posedge clk);
    req(0, rnd_dbl(), rnd_dbl());
    req(2, rnd_dbl(), rnd_dbl());
    wait_resp(n_resp + 2, 50, "post_rst_wait");
    chk("post_rst_order", 64'(pack_log()), 64'h02);

    // Randomized traffic with random latencies, some past the watchdog limit.
    fix_d = -1;
    rand_en = 1'b1;
    repeat (3000) @(posedge clk);
    rand_en = 1'b0;
    begin
      int c;
      bit any;
      c = 0;
      any = 1'b1;
      while (any && c < 500) begin
        @(posedge clk);
        c++;
        any = 1'b0;
        for (int i = 0; i < N; i++) if (pend[i]) any = 1'b1;
      end
      if (any) begin
        n_cmp++; n_err++;
        $display("FAIL drain: requests still pending after %0d cycles, expected none", c);
      end
    end
    repeat (3) @(negedge clk);
    chk("drain_grant_q", 64'(gq.size()), 64'(0));
    chk("drain_resp_q", 64'(rq.size()), 64'(0));
    chk("drain_op_count", 64'(op_count), 64'(m_ops));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/fp_op_arbiter.md
Name: fp_op_arbiter

Overview:
- Round-robin arbiter that shares one variable-latency FP unit among NUM_REQ covariance-update (CMU) requesters.
- The FP unit is an fp_multiplier or fp_adder with a valid/finish pulse handshake.
- Issues one operation at a time, tracks the owning requester and routes the result back.
- Guards against a hung unit with a watchdog and keeps a completed-operation counter.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DBL_WIDTH, 64, operand/result width (IEEE-754 double)
TIMEOUT_CYCLES, 255, max WAIT cycles before abort; 0 disables the watchdog

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request; held high until req_ready
req_a  in  NUM_REQ*DBL_WIDTH  operand A; requester i at [i*DBL_WIDTH +: DBL_WIDTH]
req_b  in  NUM_REQ*DBL_WIDTH  operand B; same packing
req_ready  out  NUM_REQ  one-cycle grant/accept pulse, one-hot
resp_valid  out  NUM_REQ  one-cycle result pulse to owner, one-hot
resp_result  out  DBL_WIDTH  result, valid while resp_valid is high, held afterwards
unit_valid  out  1  one-cycle start pulse to the FP unit
unit_a  out  DBL_WIDTH  FP unit operand A (registered)
unit_b  out  DBL_WIDTH  FP unit operand B (registered)
unit_finish  in  1  FP unit completion pulse
unit_result  in  DBL_WIDTH  FP unit result, valid with unit_finish
busy  out  1  high while an operation is in flight (state WAIT)
timeout_err  out  1  sticky; set on watchdog abort
op_count  out  16  completed operations (normal or aborted), wraps at 0xFFFF->0

Behaviour:
- Reset (rst_n low, asynchronous) drives these outputs to 0: req_ready, resp_valid, resp_result, unit_valid, unit_a, unit_b, busy, timeout_err, op_count.
- Reset also sets state to IDLE, last_grant to NUM_REQ-1 and the watchdog counter to 0.
- Reset is the only way to clear timeout_err.
- FSM has two states, IDLE and WAIT.
- IDLE:
  - If any req_valid bit is high, select index g: the first set bit searching last_grant+1, last_grant+2, ... with wrap modulo NUM_REQ, ending at last_grant.
  - At that clock edge register: unit_a/unit_b <= operands of g; unit_valid <= 1; req_ready[g] <= 1; owner <= g; last_grant <= g; busy <= 1; watchdog <= 0; state <= WAIT.
  - With no requests, remain in IDLE.
- unit_valid and req_ready are single-cycle pulses, cleared on the following edge.
- unit_a/unit_b hold their value until the next grant.
- WAIT:
  - Requests are not sampled; req_ready stays low.
  - On an edge with unit_finish=1: resp_result <= unit_result; resp_valid[owner] <= 1; op_count++; busy <= 0; state <= IDLE.
  - Otherwise the watchdog increments.
  - If TIMEOUT_CYCLES != 0 and the watchdog reaches TIMEOUT_CYCLES: resp_result <= 64'h7FF8_0000_0000_0000 (qNaN); resp_valid[owner] <= 1; timeout_err <= 1; op_count++; busy <= 0; state <= IDLE.
  - If unit_finish arrives on the same edge as the timeout, finish wins and no error is flagged.
- Latency:
  - Grant edge is the edge after req_valid is seen in IDLE.
  - Response edge is the edge after unit_finish.
  - Minimum spacing between consecutive grants is 2 cycles: the response edge, then the next grant edge.
- unit_finish while in IDLE (stray, or from an op issued before a reset) is ignored: no resp_valid, no count change.
- Requester protocol:
  - Operands are sampled only at the grant edge.
  - A requester dropping req_valid before its grant is simply skipped.
  - A requester must not re-request until it receives its resp_valid; the arbiter does not queue.
- Reset mid-WAIT aborts silently: no resp_valid is emitted.

Test Plan:
- Single request: req_valid=4'b0001, a=3.0 (0x4008000000000000), b=2.0; unit_finish 5 cycles after unit_valid with result 6.0 -> req_ready[0] and unit_valid pulse on the same edge; unit_a=0x4008..; resp_valid[0] one edge after finish; resp_result=0x4018000000000000; op_count=1.
- All four requesting simultaneously from reset, each held until its grant -> grant order 0,1,2,3; each resp_valid goes only to the matching index; grant edges at least 2 cycles apart; op_count=4.
- Fairness: after grant to 2, requesters 0 and 3 both request -> 3 is granted before 0.
- Watchdog: TIMEOUT_CYCLES=8, unit_finish never asserted -> after 8 WAIT cycles resp_valid[owner] pulses with 0x7FF8000000000000; timeout_err stays 1; the next request is still served normally.
- Finish coincides with the final watchdog cycle -> real result returned; timeout_err stays 0.
- Reset mid-WAIT, then a late unit_finish pulse in IDLE -> all outputs 0, no resp_valid, op_count stays 0; the next grant goes to requester 0.
